// File: rtl/periph_clk_gate_seq.sv
// rtl/periph_clk_gate_seq.sv - per-peripheral clock-gate sequencer with idle handshake
//
// Purpose:
//   One independent FSM per channel (OFF, WAKE, ON, DRAIN). The channel runs a
//   handshake with its peripheral instead of forwarding the register bit
//   straight to the gating cell. The peripheral must acknowledge idle before
//   its clock stops. The clock must run WAKE_CYCLES before the idle request is
//   released.
//   Optional feature macro: CLK_GATE_TIMEOUT_EN. When it is defined, a DRAIN
//   that gets no acknowledge within TIMEOUT_CYCLES forces OFF and sets a
//   sticky timeout flag.
//
// Ports:
//   HCLK           system clock, rising edge
//   HRESETn        asynchronous active-low reset
//   clk_gate_i     requested clock state per channel (1 = on)
//   idle_ack_i     peripheral quiescent; used only in DRAIN
//   timeout_clr_i  pulse clearing all sticky timeout flags
//   clk_en_o       enable to clock-gating cell per channel
//   idle_req_o     idle request to peripheral per channel
//   status_o       channel stably ON
//   busy_o         any channel in WAKE or DRAIN
//   timeout_o      sticky per-channel drain-timeout flag

module periph_clk_gate_seq #(
  parameter int NUM_PERIPH     = 8,
  parameter int WAKE_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [NUM_PERIPH-1:0] clk_gate_i,
  input  logic [NUM_PERIPH-1:0] idle_ack_i,
  input  logic                  timeout_clr_i,
  output logic [NUM_PERIPH-1:0] clk_en_o,
  output logic [NUM_PERIPH-1:0] idle_req_o,
  output logic [NUM_PERIPH-1:0] status_o,
  output logic                  busy_o,
  output logic [NUM_PERIPH-1:0] timeout_o
);

`ifdef CLK_GATE_TIMEOUT_EN
  localparam int CNT_MAX = (WAKE_CYCLES > TIMEOUT_CYCLES) ? WAKE_CYCLES : TIMEOUT_CYCLES;
`else
  localparam int CNT_MAX = WAKE_CYCLES;
`endif
  localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state_q [NUM_PERIPH];
  state_t           state_d [NUM_PERIPH];
  logic [CNT_W-1:0] cnt_q   [NUM_PERIPH];
  logic [CNT_W-1:0] cnt_d   [NUM_PERIPH];
  logic [NUM_PERIPH-1:0] busy_vec;
  logic [NUM_PERIPH-1:0] to_set;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_PERIPH; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PERIPH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    to_set = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (clk_gate_i[i]) begin
            state_d[i] = ST_WAKE;
            cnt_d[i]   = CNT_W'(WAKE_CYCLES - 1);
          end
        end
        // A gate drop during WAKE is deliberately ignored; ON handles it next.
        ST_WAKE: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = ST_ON;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        ST_ON: begin
          if (!clk_gate_i[i]) begin
            state_d[i] = ST_DRAIN;
`ifdef CLK_GATE_TIMEOUT_EN
            cnt_d[i]   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        ST_DRAIN: begin
          // Re-enable beats a same-cycle ack because the clock never stopped.
          if (clk_gate_i[i]) begin
            state_d[i] = ST_ON;
          end else if (idle_ack_i[i]) begin
            state_d[i] = ST_OFF;
`ifdef CLK_GATE_TIMEOUT_EN
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_OFF;
            to_set[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
`endif
          end
        end
        default: begin
          state_d[i] = ST_OFF;
        end
      endcase
    end
  end

  // Moore outputs from registered state only.
  always_comb begin
    clk_en_o   = '0;
    idle_req_o = '1;
    status_o   = '0;
    busy_vec   = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      case (state_q[i])
        ST_OFF: begin
          clk_en_o[i]   = 1'b0;
          idle_req_o[i] = 1'b1;
        end
        ST_WAKE: begin
          clk_en_o[i]   = 1'b1;
          idle_req_o[i] = 1'b1;
          busy_vec[i]   = 1'b1;
        end
        ST_ON: begin
          clk_en_o[i]   = 1'b1;
          idle_req_o[i] = 1'b0;
          status_o[i]   = 1'b1;
        end
        ST_DRAIN: begin
          clk_en_o[i]   = 1'b1;
          idle_req_o[i] = 1'b1;
          busy_vec[i]   = 1'b1;
        end
        default: begin
          clk_en_o[i]   = 1'b0;
          idle_req_o[i] = 1'b1;
        end
      endcase
    end
  end

  assign busy_o = |busy_vec;

`ifdef CLK_GATE_TIMEOUT_EN
  logic [NUM_PERIPH-1:0] timeout_q;

  // Set wins over a same-cycle clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      timeout_q <= '0;
    end else begin
      timeout_q <= (timeout_q & ~{NUM_PERIPH{timeout_clr_i}}) | to_set;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_clr_i | (|to_set);
  assign timeout_o      = '0;
`endif

endmodule

// File: tb/tb_periph_clk_gate_seq.sv
// tb/tb_periph_clk_gate_seq.sv - self-checking bench for periph_clk_gate_seq

module tb_periph_clk_gate_seq;

  localparam int N  = 8;
  localparam int WC = 4;
  localparam int TC = 16;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic [N-1:0] clk_gate_i = '0;
  logic [N-1:0] idle_ack_i = '0;
  logic         timeout_clr_i = 1'b0;
  logic [N-1:0] clk_en_o;
  logic [N-1:0] idle_req_o;
  logic [N-1:0] status_o;
  logic         busy_o;
  logic [N-1:0] timeout_o;

  int checks = 0;
  int failures = 0;

  periph_clk_gate_seq #(
    .NUM_PERIPH(N),
    .WAKE_CYCLES(WC),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .clk_gate_i(clk_gate_i),
    .idle_ack_i(idle_ack_i),
    .timeout_clr_i(timeout_clr_i),
    .clk_en_o(clk_en_o),
    .idle_req_o(idle_req_o),
    .status_o(status_o),
    .busy_o(busy_o),
    .timeout_o(timeout_o)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [7:0] gate;
    logic [7:0] ack;
    logic       clr;
    logic [7:0] e_clk;
    logic [7:0] e_idle;
    logic [7:0] e_stat;
    logic       e_busy;
    logic [7:0] e_to;
  } vec_t;

  vec_t vecs [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_clk, input logic [7:0] e_idle,
                         input logic [7:0] e_stat, input logic e_busy, input logic [7:0] e_to);
    chk({tag, ".clk_en"},   32'(clk_en_o),   32'(e_clk));
    chk({tag, ".idle_req"}, 32'(idle_req_o), 32'(e_idle));
    chk({tag, ".status"},   32'(status_o),   32'(e_stat));
    chk({tag, ".busy"},     32'(busy_o),     32'(e_busy));
    chk({tag, ".timeout"},  32'(timeout_o),  32'(e_to));
  endtask

  // Drive inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic [7:0] gate, input logic [7:0] ack, input logic clr);
    @(negedge HCLK);
    clk_gate_i    = gate;
    idle_ack_i    = ack;
    timeout_clr_i = clr;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    //           gate   ack    clr   clk    idle   stat   busy  to
    vecs[0]  = '{8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00}; // idle after reset
    vecs[1]  = '{8'h01, 8'h00, 1'b0, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00}; // ch0 wake, clk on now
    vecs[2]  = '{8'h01, 8'h00, 1'b0, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00};
    vecs[3]  = '{8'h01, 8'h00, 1'b0, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00};
    vecs[4]  = '{8'h01, 8'h00, 1'b0, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00};
    vecs[5]  = '{8'h01, 8'h00, 1'b0, 8'h01, 8'hFE, 8'h01, 1'b0, 8'h00}; // ON at k+4
    vecs[6]  = '{8'h01, 8'h00, 1'b0, 8'h01, 8'hFE, 8'h01, 1'b0, 8'h00};
    vecs[7]  = '{8'h00, 8'h00, 1'b0, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00}; // DRAIN
    vecs[8]  = '{8'h00, 8'h00, 1'b0, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00};
    vecs[9]  = '{8'h00, 8'h00, 1'b0, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00};
    vecs[10] = '{8'h00, 8'h01, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00}; // ack -> OFF
    vecs[11] = '{8'h00, 8'h01, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00}; // ack ignored in OFF
    vecs[12] = '{8'h01, 8'h00, 1'b0, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00};
    vecs[13] = '{8'h01, 8'h00, 1'b0, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00};
    vecs[14] = '{8'h01, 8'h00, 1'b0, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00};
    vecs[15] = '{8'h01, 8'h00, 1'b0, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00};
    vecs[16] = '{8'h01, 8'h00, 1'b0, 8'h01, 8'hFE, 8'h01, 1'b0, 8'h00};
    vecs[17] = '{8'h00, 8'h00, 1'b0, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00}; // DRAIN
    vecs[18] = '{8'h01, 8'h01, 1'b0, 8'h01, 8'hFE, 8'h01, 1'b0, 8'h00}; // abort beats ack
    vecs[19] = '{8'h02, 8'h02, 1'b0, 8'h03, 8'hFF, 8'h00, 1'b1, 8'h00}; // ch0 drain, ch1 wake
    vecs[20] = '{8'h03, 8'h00, 1'b0, 8'h03, 8'hFE, 8'h01, 1'b1, 8'h00}; // ch0 back ON
    vecs[21] = '{8'h03, 8'h00, 1'b0, 8'h03, 8'hFE, 8'h01, 1'b1, 8'h00};
    vecs[22] = '{8'h03, 8'h00, 1'b0, 8'h03, 8'hFE, 8'h01, 1'b1, 8'h00};
    vecs[23] = '{8'h03, 8'h00, 1'b0, 8'h03, 8'hFC, 8'h03, 1'b0, 8'h00}; // ch1 ON
    vecs[24] = '{8'h00, 8'h00, 1'b0, 8'h03, 8'hFF, 8'h00, 1'b1, 8'h00}; // both DRAIN
    vecs[25] = '{8'h00, 8'h03, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00}; // both OFF

    // Reset values while HRESETn is held low.
    @(posedge HCLK);
    #1;
    chk_all("reset", 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int v = 0; v < 26; v++) begin
      step(vecs[v].gate, vecs[v].ack, vecs[v].clr);
      chk_all($sformatf("vec%0d", v), vecs[v].e_clk, vecs[v].e_idle, vecs[v].e_stat,
              vecs[v].e_busy, vecs[v].e_to);
    end

    // Long drain with no acknowledge.
    for (int i = 0; i < WC + 1; i++) step(8'h01, 8'h00, 1'b0);
    chk("drain_pre.status", 32'(status_o), 32'h01);
    step(8'h00, 8'h00, 1'b0);                              // DRAIN entered at edge k
    for (int i = 0; i < TC - 1; i++) step(8'h00, 8'h00, 1'b0);
    chk_all("drain_k+15", 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00);
    step(8'h00, 8'h00, 1'b0);                              // edge k+16
`ifdef CLK_GATE_TIMEOUT_EN
    chk_all("timeout_k+16", 8'h00, 8'hFF, 8'h00, 1'b0, 8'h01);
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 1'b0);
    chk("timeout_sticky", 32'(timeout_o), 32'h01);
    step(8'h00, 8'h00, 1'b1);
    chk("timeout_clr", 32'(timeout_o), 32'h00);
    step(8'h00, 8'h00, 1'b0);
    chk("timeout_after_clr", 32'(timeout_o), 32'h00);
`else
    chk_all("no_timeout_k+16", 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < 1000 - TC; i++) step(8'h00, 8'h00, 1'b0);
    chk_all("drain_edge1000", 8'h01, 8'hFF, 8'h00, 1'b1, 8'h00);
    step(8'h00, 8'h00, 1'b1);
    chk("clr_unused.timeout", 32'(timeout_o), 32'h00);
    step(8'h00, 8'h01, 1'b0);
    chk_all("late_ack", 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00);
`endif

    // Asynchronous reset with ch3 mid-WAKE and ch5 mid-DRAIN.
    for (int i = 0; i < WC + 1; i++) step(8'h20, 8'h00, 1'b0);
    chk("ch5_on.status", 32'(status_o), 32'h20);
    step(8'h08, 8'h00, 1'b0);
    step(8'h08, 8'h00, 1'b0);
    chk_all("pre_reset", 8'h28, 8'hFF, 8'h00, 1'b1, 8'h00);
    #2;
    HRESETn = 1'b0;
    #1;
    chk_all("async_reset", 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00);
    @(negedge HCLK);
    clk_gate_i = '0;
    HRESETn    = 1'b1;
    step(8'h28, 8'h00, 1'b0);
    chk_all("rewake", 8'h28, 8'hFF, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < WC - 1; i++) step(8'h28, 8'h00, 1'b0);
    chk("rewake_k+3.status", 32'(status_o), 32'h00);
    step(8'h28, 8'h00, 1'b0);
    chk_all("rewake_on", 8'h28, 8'hD7, 8'h28, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/periph_clk_gate_seq.md
# periph_clk_gate_seq

Per-peripheral clock-gate sequencer that sits directly downstream of the SoC control register block and consumes its clock-gate register output. It does not forward a register bit straight to a gating cell. Each channel runs a handshake with its peripheral: the peripheral must signal idle before its clock stops, and the clock must run for a settle period before the peripheral is released. One independent FSM per channel; channel outputs drive the clock-gating cells and the peripherals' idle-request inputs.

## Interface
- NUM_PERIPH, default 8: number of gated peripherals/channels (1..32).
- WAKE_CYCLES, default 4: clock-running cycles before idle request drops on wake-up (>=1).
- TIMEOUT_CYCLES, default 256: drain timeout in cycles (>=1); used only with `CLK_GATE_TIMEOUT_EN`.
- HCLK  input  1  system clock; all state on rising edge.
- HRESETn  input  1  asynchronous, active-low reset.
- clk_gate_i  input  NUM_PERIPH  requested clock state per channel from the control register (1 = clock on).
- idle_ack_i  input  NUM_PERIPH  peripheral reports quiescent; meaningful only while its idle_req_o = 1.
- timeout_clr_i  input  1  single-cycle pulse that clears all sticky timeout flags.
- clk_en_o  output  NUM_PERIPH  enable to clock-gating cell per channel.
- idle_req_o  output  NUM_PERIPH  request to the peripheral to reach and hold idle.
- status_o  output  NUM_PERIPH  1 = channel stably ON (readback).
- busy_o  output  1  OR over all channels in WAKE or DRAIN.
- timeout_o  output  NUM_PERIPH  sticky per-channel flag: drain ended by timeout.

## Operation
- Each channel has the states OFF, WAKE, ON and DRAIN, plus a down-counter of width $clog2(max(WAKE_CYCLES, TIMEOUT_CYCLES)+1).
- Outputs are Moore outputs, decoded from registered state only:
  - OFF: clk_en 0, idle_req 1, status 0.
  - WAKE: clk_en 1, idle_req 1, status 0.
  - ON: clk_en 1, idle_req 0, status 1.
  - DRAIN: clk_en 1, idle_req 1, status 0.
- OFF -> WAKE when clk_gate_i = 1. The counter loads WAKE_CYCLES-1.
- WAKE: the counter decrements each cycle. WAKE -> ON at count 0. clk_gate_i is ignored in WAKE, so WAKE always completes; a drop is handled from ON.
- ON -> DRAIN when clk_gate_i = 0. The counter loads TIMEOUT_CYCLES-1.
- DRAIN transitions, in priority order:
  - clk_gate_i = 1 -> ON. The abort wins over a same-cycle ack because the clock never stopped.
  - idle_ack_i = 1 -> OFF.
  - (macro only) counter = 0 -> OFF, and set timeout_o.
  - Otherwise stay in DRAIN and decrement the counter.
- idle_ack_i is ignored in OFF, WAKE and ON.
- timeout_o:
  - Set has priority over timeout_clr_i in the same cycle.
  - timeout_clr_i clears all flags.
- Channels are fully independent; simultaneous transitions on any subset are legal.

## Timing
- Reset, asynchronous on HRESETn low, mid-operation included: every channel goes to OFF immediately.
  - clk_en_o = 0, idle_req_o = all ones, status_o = 0, busy_o = 0, timeout_o = 0.
  - Counters are cleared.
- Wake latency: clk_gate_i high sampled at edge k gives:
  - clk_en_o = 1 after edge k.
  - idle_req_o = 0 and status_o = 1 after edge k+WAKE_CYCLES.
- Gate latency: clk_gate_i low sampled at edge k means DRAIN after edge k. An ack sampled at edge m > k means clk_en_o = 0 after edge m.
- Minimum OFF->ON->OFF round trip is WAKE_CYCLES+2 edges.
- Timeout: with no ack, DRAIN entered at edge k exits to OFF after edge k+TIMEOUT_CYCLES; timeout_o goes high at that same edge.
- busy_o is combinational from the registered state; it adds no extra cycle.

## Configuration
- `CLK_GATE_TIMEOUT_EN` defined:
  - A DRAIN exceeding TIMEOUT_CYCLES forces OFF and sets the sticky timeout_o bit.
- Undefined:
  - DRAIN waits indefinitely for idle_ack_i or a re-enable.
  - timeout_o is tied to 0 and timeout_clr_i is unused.
  - The counter width depends only on WAKE_CYCLES.

## Test plan
- Reset, then hold clk_gate_i = 0 -> clk_en_o = 0x00, idle_req_o = 0xFF, status_o = 0x00, busy_o = 0.
- clk_gate_i = 0x01 at edge 10, WAKE_CYCLES = 4 -> clk_en_o[0] = 1 after edge 10; idle_req_o[0] = 0 and status_o[0] = 1 after edge 14; busy_o high for edges 10..13.
- Channel 0 ON, clk_gate_i = 0x00 at edge 20, idle_ack_i[0] = 1 at edge 23 -> DRAIN from 20; clk_en_o[0] = 0 after edge 23; timeout_o = 0.
- DRAIN, then at edge 25 clk_gate_i[0] = 1 and idle_ack_i[0] = 1 together -> channel returns to ON, clk_en_o[0] stays 1, idle_req_o[0] = 0 after edge 25.
- `CLK_GATE_TIMEOUT_EN`, TIMEOUT_CYCLES = 16, no ack, DRAIN entered at edge 40:
  - OFF and timeout_o[0] = 1 after edge 56.
  - timeout_clr_i pulse at edge 60 clears timeout_o to 0.
  - Without the macro, the channel is still in DRAIN at edge 1000.
- HRESETn low mid-WAKE on channel 3 and mid-DRAIN on channel 5 -> immediately all OFF with the reset values above; after release, clk_gate_i = 0x28 restarts both wakes.
